// File: rtl/flash_console_pkg.sv
// Shared types and defaults for the flash dump console: FSM states and
// default timing constants used by the controller and its debouncers.
package flash_console_pkg;

  typedef enum logic [2:0] {
    ST_START,
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 270000;
  localparam int DEF_TIMEOUT_CYCLES  = 1 << 24;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw active-low button and emits a one-cycle pulse when a
// press (1->0) has been stable for DEBOUNCE_CYCLES clocks.
module btn_debounce
  import flash_console_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d  = btn_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    // Any return to the accepted level restarts the count from zero.
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_pulse = press_q;

endmodule

// File: rtl/flash_dump_ctrl.sv
// Button-driven flash dump controller: steps a burst-aligned address with two
// debounced buttons, reads one burst per step and streams it to the UART.
module flash_dump_ctrl
  import flash_console_pkg::*;
#(
  parameter int ADDR_W          = 24,
  parameter int BURST_LEN       = 1,
  parameter int ADDR_LIMIT      = 1 << 24,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int AUTO_START      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_next_n,
  input  logic                   btn_prev_n,
  output logic [ADDR_W-1:0]      flash_addr,
  output logic                   flash_req,
  input  logic [BURST_LEN*8-1:0] flash_data,
  input  logic                   flash_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int DW = BURST_LEN * 8;
  localparam int IW = cnt_w(BURST_LEN);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);

  logic press_next, press_prev;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_n       (btn_next_n),
    .press_pulse (press_next)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_n       (btn_prev_n),
    .press_pulse (press_prev)
  );

  state_e          state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            pend_next_q, pend_next_d;
  logic            pend_prev_q, pend_prev_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   burst_q, burst_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] addr_next, addr_prev;
  logic [DW-1:0]     burst_shift;

  always_comb begin
    addr_sum    = {1'b0, addr_q} + (ADDR_W + 1)'(BURST_LEN);
    addr_next   = (addr_sum >= (ADDR_W + 1)'(ADDR_LIMIT)) ? '0 : addr_sum[ADDR_W-1:0];
    addr_prev   = (addr_q == '0) ? ADDR_W'(ADDR_LIMIT - BURST_LEN)
                                 : addr_q - ADDR_W'(BURST_LEN);
    burst_shift = burst_q << 8;
  end

  // UART handshake: a byte transfers on any cycle where tx_valid && tx_ready;
  // tx_valid/tx_data are registered and held unchanged until that happens.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_d       = 1'b0;
    pend_next_d = pend_next_q;
    pend_prev_d = pend_prev_q;
    tmo_d       = tmo_q;
    burst_d     = burst_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    err_d       = err_q;

    case (state_q)
      ST_START: begin
        if (AUTO_START != 0) begin
          addr_d  = '0;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pend_next_q ^ pend_prev_q) begin
          addr_d      = pend_next_q ? addr_next : addr_prev;
          pend_next_d = 1'b0;
          pend_prev_d = 1'b0;
          req_d       = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flash_valid) begin
          burst_d    = flash_data;
          idx_d      = '0;
          tx_data_d  = flash_data[DW-1 -: 8];
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (idx_q == IW'(BURST_LEN - 1)) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            idx_d     = idx_q + 1'b1;
            burst_d   = burst_shift;
            tx_data_d = burst_shift[DW-1 -: 8];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // New presses merge into the flags; opposite directions cancel out.
    pend_next_d = pend_next_d | press_next;
    pend_prev_d = pend_prev_d | press_prev;
    if (pend_next_d && pend_prev_d) begin
      pend_next_d = 1'b0;
      pend_prev_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_START;
      addr_q      <= '0;
      req_q       <= 1'b0;
      pend_next_q <= 1'b0;
      pend_prev_q <= 1'b0;
      tmo_q       <= '0;
      burst_q     <= '0;
      idx_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      pend_next_q <= pend_next_d;
      pend_prev_q <= pend_prev_d;
      tmo_q       <= tmo_d;
      burst_q     <= burst_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign flash_addr  = addr_q;
  assign flash_req   = req_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: doc/flash_dump_ctrl.md
Name: flash_dump_ctrl

Overview:
- Parametrised controller between the board buttons, the flash reader (flashNavigator) and the UART transmitter.
- Debounces two active-low buttons to step a flash address forward or back, then issues one read request of BURST_LEN bytes per step.
- Serialises the returned burst byte-by-byte into the UART through a valid/ready handshake.
- Replaces free-running counters and button-clocked logic with a single-clock FSM that adds reset, backward stepping, wrap, a read timeout and a busy/error status.

Parameters:
- ADDR_W, 24, flash address width.
- BURST_LEN, 1, bytes per read; must be >= 1.
- ADDR_LIMIT, 2**24, exclusive upper address bound; must be a multiple of BURST_LEN.
- DEBOUNCE_CYCLES, 270000, cycles a button level must be stable before it is accepted (10 ms at 27 MHz).
- TIMEOUT_CYCLES, 2**24, maximum wait for flash_valid after a request.
- AUTO_START, 1, when 1, a read of address 0 is issued automatically after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_next_n  in  1  raw button, active-low, asynchronous to clk
- btn_prev_n  in  1  raw button, active-low, asynchronous to clk
- flash_addr  out  ADDR_W  read address to flash reader
- flash_req  out  1  one-cycle read start pulse
- flash_data  in  BURST_LEN*8  burst returned by flash reader
- flash_valid  in  1  flash_data valid; sampled as a level
- tx_data  out  8  byte to UART
- tx_valid  out  1  byte offered to UART
- tx_ready  in  1  UART accepts byte when tx_valid && tx_ready
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky; set on read timeout, cleared only by reset

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - flash_addr=0, flash_req=0, tx_valid=0, tx_data=0, err_timeout=0.
  - All pending-press flags are cleared.
  - Debouncers load the released (1) state.
  - FSM enters START.
- Button inputs:
  - Each raw button passes through a 2-flop synchroniser, then a debounce counter.
  - The counter resets on any level change and accepts the new level when it reaches DEBOUNCE_CYCLES-1.
  - A press event is a one-cycle pulse on an accepted 1->0 transition; releases generate nothing.
- Pending presses:
  - Each press sets pend_next or pend_prev.
  - If both are set in the same cycle, both clear (net zero).
  - A press arriving while the opposite flag is pending cancels it.
- Address arithmetic, evaluated on leaving IDLE:
  - next: addr = addr + BURST_LEN; if the result is >= ADDR_LIMIT, addr = 0.
  - prev: if addr == 0, addr = ADDR_LIMIT - BURST_LEN; else addr = addr - BURST_LEN.
- FSM states:
  - START: if AUTO_START, go to REQ with addr 0; otherwise go to IDLE.
  - IDLE: if exactly one pend flag is set, update flash_addr, clear the flag, go to REQ.
  - REQ: flash_req=1 for exactly one cycle, clear the timeout counter, go to WAIT.
  - WAIT: on flash_valid, capture flash_data into the burst shift register, set byte index=0, go to SEND. If the timeout counter reaches TIMEOUT_CYCLES-1, set err_timeout and go to IDLE.
  - SEND: tx_valid=1 with tx_data = current byte. On tx_valid && tx_ready: if index == BURST_LEN-1, deassert tx_valid and go to IDLE; else index++, shift, stay in SEND.
- Byte order: byte 0 is flash_data[BURST_LEN*8-1 -: 8], i.e. the first byte read from flash goes out first.
- Handshake: tx_data is stable while tx_valid=1 and !tx_ready. No combinational path from tx_ready to tx_valid or tx_data.
- Latency:
  - Accepted press to flash_req: 2 cycles (IDLE, then REQ).
  - flash_valid to tx_valid: 1 cycle.
- Presses during a transaction: remain pending and are serviced on return to IDLE; one pending press per direction, extra presses are merged.
- Reset mid-transaction: outputs return to reset values immediately; a UART byte in flight is the UART's concern.

Decomposition:
- Shared package flash_console_pkg: FSM state enum (START, IDLE, REQ, WAIT, SEND) and the default DEBOUNCE_CYCLES / TIMEOUT_CYCLES constants.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_n, press_pulse), instantiated twice.

Test Plan:
- Power-up, AUTO_START=1, BURST_LEN=1:
  - Stimulus: release rst_n; reply flash_valid with 8'hA5; tx_ready=1.
  - Required: one flash_req with flash_addr=0; tx_data=8'hA5 for exactly one handshake; then IDLE, busy=0.
- BURST_LEN=4:
  - Stimulus: next press; flash_data=32'h11223344; tx_ready toggling 1-of-3 cycles.
  - Required: flash_addr=4; bytes 11,22,33,44 in order; tx_data stable while stalled.
- Wrap, ADDR_LIMIT=16, BURST_LEN=4:
  - Stimulus: prev press at addr 0.
  - Required: flash_addr=12.
  - Stimulus: three next presses from 12.
  - Required: addresses 0, 4, 8.
- Bounce, DEBOUNCE_CYCLES=8:
  - Stimulus: btn_next_n glitches low for 5 cycles, 3 times, then held low for 20 cycles.
  - Required: exactly one flash_req.
- Timeout, TIMEOUT_CYCLES=32:
  - Stimulus: flash_valid never asserted.
  - Required: err_timeout=1 on the 32nd WAIT cycle; FSM back in IDLE; a later next press still issues flash_req.
- Pending presses and reset:
  - Stimulus: next press during SEND.
  - Required: serviced right after the burst completes.
  - Stimulus: next and prev pressed in the same cycle.
  - Required: no request.
  - Stimulus: rst_n pulsed low in WAIT.
  - Required: all outputs at reset values within the same cycle.
